// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV64I-subset core (add/sub/addi/ld/sd/beq, ecall/ebreak halt) with an internal
// control FSM and req/ack handshakes toward instruction and data memories.
module riscv_multicycle_core #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic            CLK,
  input  logic            RST,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic            halted,
  output logic            illegal
);

  localparam int unsigned NREGS = 32;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;

  state_e          state_q, state_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] rf_d [NREGS];
  logic            imem_req_q, imem_req_d, dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
  logic            retire_q, retire_d, halted_q, halted_d, illegal_q, illegal_d;

  // Instruction fields, held stable in IR from DECODE to retirement
  logic [6:0]      opcode, funct7;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b;
  logic            is_r, is_addi, is_ld, is_sd, is_beq, is_sys;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  assign imm_i = XLEN'($signed(ir_q[31:20]));
  assign imm_s = XLEN'($signed({ir_q[31:25], ir_q[11:7]}));
  assign imm_b = XLEN'($signed({ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0}));

  assign is_r    = (opcode == OP_R) && (funct3 == 3'd0) &&
                   ((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
  assign is_addi = (opcode == OP_IMM) && (funct3 == 3'd0);
  assign is_ld   = (opcode == OP_LD)  && (funct3 == 3'd3);
  assign is_sd   = (opcode == OP_ST)  && (funct3 == 3'd3);
  assign is_beq  = (opcode == OP_BR)  && (funct3 == 3'd0);
  assign is_sys  = (opcode == OP_SYS);

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    pc_d      = pc_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    rf_d      = rf_q;
    illegal_d = illegal_q;
    retire_d  = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d = (rs1 == 5'd0) ? '0 : rf_q[rs1];
        b_d = (rs2 == 5'd0) ? '0 : rf_q[rs2];
        if (is_sys) begin
          state_d   = S_HALT;
          illegal_d = 1'b0;
        end else if (!(is_r || is_addi || is_ld || is_sd || is_beq)) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_beq) begin
          pc_d     = (a_q == b_q) ? pc_q + imm_b : pc_q + XLEN'(4);
          retire_d = 1'b1;
          state_d  = S_FETCH;
        end else begin
          if (is_r) alu_d = funct7[5] ? a_q - b_q : a_q + b_q;
          else      alu_d = a_q + (is_sd ? imm_s : imm_i);
          state_d = (is_ld || is_sd) ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (is_ld) begin
            mdr_d   = dmem_rdata;
            state_d = S_WB;
          end else begin
            pc_d     = pc_q + XLEN'(4);
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end
        end
      end
      S_WB: begin
        if (rd != 5'd0) rf_d[rd] = is_ld ? mdr_q : alu_q;
        pc_d     = pc_q + XLEN'(4);
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    imem_req_d = (state_d == S_FETCH);
    dmem_req_d = (state_d == S_MEM);
    dmem_we_d  = (state_d == S_MEM) && is_sd;
    halted_d   = (state_d == S_HALT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_FETCH;
      ir_q       <= '0;
      pc_q       <= PC_RESET;
      a_q        <= '0;
      b_q        <= '0;
      alu_q      <= '0;
      mdr_q      <= '0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      imem_req_q <= 1'b1;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      retire_q   <= 1'b0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      a_q        <= a_d;
      b_q        <= b_d;
      alu_q      <= alu_d;
      mdr_q      <= mdr_d;
      rf_q       <= rf_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      retire_q   <= retire_d;
      halted_q   <= halted_d;
      illegal_q  <= illegal_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = alu_q;
  assign dmem_wdata = b_q;
  assign pc         = pc_q;
  assign retire     = retire_q;
  assign halted     = halted_q;
  assign illegal    = illegal_q;

endmodule
